psum_collector: RTL and testbench

//  Consumer end of the PE partial-sum stream. Captures psum samples qualified by
//  the PE completion flag and sums NUM_PASS kernel-row passes element-wise into an

---
 rtl/psum_collector.sv | 211 +++++++++++++++++++++
 tb/tb_psum_collector.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_collector.sv
// -----------------------------------------------------------------------------
// psum_collector
//
// Purpose:
//   Consumer end of the PE partial-sum stream. Samples qualified by the PE
//   completion flag (psum_valid) are summed element-wise over NUM_PASS
//   kernel-row passes into an internal row buffer. Once the final pass has
//   landed, each element gets a bias added. It is then arithmetically
//   right-shifted by SHIFT, saturated to DATA_WIDTH signed, and streamed out
//   over a valid/ready handshake.
//
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous reset, active low
//   start       in   one-cycle pulse that begins a new output row (IDLE only)
//   bias_in     in   signed bias, captured with the accepted start
//   psum_valid  in   psum_in carries a sample this cycle
//   psum_in     in   signed partial sum from the PE array
//   out_valid   out  out_data / out_last are valid
//   out_ready   in   downstream accepts when out_valid && out_ready
//   out_data    out  requantized, saturated signed element
//   out_last    out  marks the final element of the row
//   busy        out  high while accumulating or draining
//   done        out  one-cycle pulse after the last element handshakes
//   drop_err    out  sticky; a sample arrived outside accumulation
//
// Configuration macro:
//   RELU_EN  when defined, negative saturated results are clamped to zero.
// -----------------------------------------------------------------------------
module psum_collector #(
  parameter int DATA_WIDTH = 8,
  parameter int PSUM_WIDTH = 18,
  parameter int ACC_WIDTH  = 22,
  parameter int ROW_LEN    = 26,
  parameter int NUM_PASS   = 3,
  parameter int SHIFT      = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic signed [ACC_WIDTH-1:0]  bias_in,
  input  logic                         psum_valid,
  input  logic signed [PSUM_WIDTH-1:0] psum_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done,
  output logic                         drop_err
);

  // Counter widths. The pass counter is kept at least one bit wide so a
  // single-pass configuration still elaborates.
  localparam int IW = (ROW_LEN  > 1) ? $clog2(ROW_LEN)  : 1;
  localparam int PW = (NUM_PASS > 1) ? $clog2(NUM_PASS) : 1;

  // The bias add is done one bit wider than the accumulator so the sum
  // itself can never wrap before saturation.
  localparam int SW = ACC_WIDTH + 1;

  localparam logic signed [SW-1:0] SAT_MAX = SW'((1 <<< (DATA_WIDTH - 1)) - 1);
  localparam logic signed [SW-1:0] SAT_MIN = SW'(-(1 <<< (DATA_WIDTH - 1)));

  localparam logic [IW-1:0] IDX_LAST  = IW'(ROW_LEN - 1);
  localparam logic [PW-1:0] PASS_LAST = PW'(NUM_PASS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]                 r_state;
  logic [IW-1:0]              r_idx;
  logic [PW-1:0]              r_pass;
  logic [IW-1:0]              r_k;
  logic signed [ACC_WIDTH-1:0] r_bias;
  logic                       r_done;
  logic                       r_drop;
  logic signed [ACC_WIDTH-1:0] r_acc [ROW_LEN];

  logic                        w_sample;
  logic                        w_idxLast;
  logic                        w_passLast;
  logic                        w_kLast;
  logic                        w_startOk;
  logic                        w_handshake;
  logic signed [ACC_WIDTH-1:0] w_psumExt;
  logic signed [SW-1:0]        w_accExt;
  logic signed [SW-1:0]        w_biasExt;
  logic signed [SW-1:0]        w_sum;
  logic signed [SW-1:0]        w_shifted;
  logic signed [DATA_WIDTH-1:0] w_sat;
  logic signed [DATA_WIDTH-1:0] w_final;

  // Control decodes shared by the FSM and the buffer write port.
  assign w_sample    = (r_state == S_ACCUM) && psum_valid;
  assign w_idxLast   = (r_idx == IDX_LAST);
  assign w_passLast  = (r_pass == PASS_LAST);
  assign w_kLast     = (r_k == IDX_LAST);
  assign w_handshake = (r_state == S_DRAIN) && out_ready;

  // A start landing in the same cycle as the done pulse belongs to the row
  // that just finished, so it is swallowed rather than opening a new row.
  assign w_startOk   = (r_state == S_IDLE) && start && !r_done;

  assign w_psumExt = {{(ACC_WIDTH - PSUM_WIDTH){psum_in[PSUM_WIDTH-1]}}, psum_in};

  // Main sequencer: walks idx across the row once per pass, then k across the
  // row during drain. done is a registered pulse and drop_err is sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_pass  <= '0;
      r_k     <= '0;
      r_bias  <= '0;
      r_done  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (psum_valid && (r_state != S_ACCUM)) begin
        r_drop <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_startOk) begin
            r_bias  <= bias_in;
            r_idx   <= '0;
            r_pass  <= '0;
            r_state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (psum_valid) begin
            if (w_idxLast) begin
              r_idx <= '0;
              if (w_passLast) begin
                r_pass  <= '0;
                r_k     <= '0;
                r_state <= S_DRAIN;
              end else begin
                r_pass <= r_pass + PW'(1);
              end
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (w_handshake) begin
            if (w_kLast) begin
              r_k     <= '0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_k <= r_k + IW'(1);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Row buffer. Contents are meaningless outside a row, so it carries no
  // reset. The first pass overwrites, which also discards any residue from
  // the previous row or from an aborted one. Later passes wrap modulo
  // 2^ACC_WIDTH.
  always_ff @(posedge clk) begin
    if (w_sample) begin
      if (r_pass == '0) begin
        r_acc[r_idx] <= w_psumExt;
      end else begin
        r_acc[r_idx] <= r_acc[r_idx] + w_psumExt;
      end
    end
  end

  // Output datapath: bias add, arithmetic shift, then clamp into the signed
  // output range. The result is a pure function of k and the buffer, so it
  // holds steady while the consumer stalls.
  always_comb begin
    w_accExt  = {r_acc[r_k][ACC_WIDTH-1], r_acc[r_k]};
    w_biasExt = {r_bias[ACC_WIDTH-1], r_bias};
    w_sum     = w_accExt + w_biasExt;
    w_shifted = w_sum >>> SHIFT;
    if (w_shifted > SAT_MAX) begin
      w_sat = SAT_MAX[DATA_WIDTH-1:0];
    end else if (w_shifted < SAT_MIN) begin
      w_sat = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      w_sat = w_shifted[DATA_WIDTH-1:0];
    end
`ifdef RELU_EN
    w_final = w_sat[DATA_WIDTH-1] ? '0 : w_sat;
`else
    w_final = w_sat;
`endif
  end

  // Data and last are gated by valid so every output reads zero outside drain.
  assign out_valid = (r_state == S_DRAIN);
  assign out_data  = out_valid ? w_final : '0;
  assign out_last  = out_valid && w_kLast;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign drop_err  = r_drop;

endmodule

// File: tb/tb_psum_collector.sv
// -----------------------------------------------------------------------------
// tb_psum_collector
//
// Table-driven bench for psum_collector. Each record describes a row, giving
// the bias, psum = base + idx*scale on every pass, and the hand-computed
// output as expBase + idx*expStep. It carries signed and RELU columns.
// Hand-written sequences cover stalls and backpressure, start coinciding with
// done, protocol errors, and reset in the middle of a drain.
// -----------------------------------------------------------------------------
module tb_psum_collector;

  localparam int ROW_LEN  = 26;
  localparam int NUM_PASS = 3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic signed [21:0] bias_in = '0;
  logic               psum_valid = 1'b0;
  logic signed [17:0] psum_in = '0;
  logic               out_ready = 1'b0;
  logic               out_valid;
  logic signed [7:0]  out_data;
  logic               out_last;
  logic               busy;
  logic               done;
  logic               drop_err;

  int nChecks = 0;
  int nFail   = 0;

  typedef struct {
    string name;
    int    bias;
    int    base;
    int    scale;
    int    sBase;
    int    sStep;
    int    rBase;
    int    rStep;
  } vec_t;

  vec_t vecs[15];

  always #5 clk = ~clk;

  psum_collector #(
    .DATA_WIDTH(8),
    .PSUM_WIDTH(18),
    .ACC_WIDTH (22),
    .ROW_LEN   (ROW_LEN),
    .NUM_PASS  (NUM_PASS),
    .SHIFT     (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bias_in   (bias_in),
    .psum_valid(psum_valid),
    .psum_in   (psum_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .drop_err  (drop_err)
  );

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Pulse start for one cycle at a negedge; on return the DUT is in ACCUM.
  task automatic startRow(input string tag, input int b);
    @(negedge clk);
    start   = 1'b1;
    bias_in = 22'(b);
    @(negedge clk);
    start = 1'b0;
    checkOutput({tag, " busy after start"}, int'(busy), 1);
  endtask

  // Feed NUM_PASS passes of psum = base + idx*scale, optionally with random
  // stall cycles and a stray start pulse on sample number injectAt.
  task automatic applyStimulus(input string tag, input int base, input int scale,
                               input bit stall, input int injectAt);
    int n = 0;
    for (int p = 0; p < NUM_PASS; p++) begin
      for (int i = 0; i < ROW_LEN; i++) begin
        if (stall) begin
          while ($urandom_range(0, 1) == 1) begin
            psum_valid = 1'b0;
            @(negedge clk);
          end
        end
        psum_valid = 1'b1;
        psum_in    = 18'(base + i * scale);
        if (n == injectAt) begin
          start   = 1'b1;
          bias_in = 22'(1000);
        end
        @(negedge clk);
        start = 1'b0;
        n++;
      end
    end
    psum_valid = 1'b0;
    checkOutput({tag, " valid one cycle after last sample"}, int'(out_valid), 1);
  endtask

  // Collect stopAt elements, checking value, last flag and hold-under-stall.
  // For a full row it then checks the done pulse and optionally fires start
  // in the done cycle, which must be ignored.
  task automatic collectRow(input string tag, input int eBase, input int eStep,
                            input bit slowReady, input int stopAt, input bit startOnDone);
    int cnt = 0;
    int cyc = 0;
    bit held = 1'b0;
    int hData = 0;
    int hLast = 0;
    while (cnt < stopAt && cyc < 3000) begin
      out_ready = slowReady ? ($urandom_range(0, 2) == 0) : 1'b1;
      checkOutput({tag, " out_valid in drain"}, int'(out_valid), 1);
      if (held) begin
        checkOutput({tag, " data held"}, int'(out_data), hData);
        checkOutput({tag, " last held"}, int'(out_last), hLast);
      end
      if (out_ready) begin
        checkOutput($sformatf("%s data[%0d]", tag, cnt), int'(out_data), eBase + cnt * eStep);
        checkOutput($sformatf("%s last[%0d]", tag, cnt), int'(out_last),
                    (cnt == ROW_LEN - 1) ? 1 : 0);
        cnt++;
      end
      held  = !out_ready;
      hData = int'(out_data);
      hLast = int'(out_last);
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    if (cnt < stopAt) begin
      checkOutput({tag, " drain timeout elements"}, cnt, stopAt);
    end
    if (stopAt == ROW_LEN) begin
      checkOutput({tag, " done pulse"}, int'(done), 1);
      checkOutput({tag, " valid dropped"}, int'(out_valid), 0);
      checkOutput({tag, " idle after row"}, int'(busy), 0);
      if (startOnDone) begin
        start   = 1'b1;
        bias_in = '0;
      end
      @(negedge clk);
      start = 1'b0;
      checkOutput({tag, " done single cycle"}, int'(done), 0);
      checkOutput({tag, " still idle"}, int'(busy), 0);
    end
  endtask

  initial begin
    int eBase;
    int eStep;

    //            name         bias   base    scale sBase sStep rBase rStep
    vecs[0]  = '{"basic",      0,     16,     0,    3,    0,    3,    0};
    vecs[1]  = '{"ramp",       0,     16,     16,   3,    3,    3,    3};
    vecs[2]  = '{"satPos",     0,     20000,  0,    127,  0,    127,  0};
    vecs[3]  = '{"satNeg",     0,     -20000, 0,    -128, 0,    0,    0};
    vecs[4]  = '{"biasPos",    40,    -8,     0,    1,    0,    1,    0};
    vecs[5]  = '{"negFloor",   0,     -8,     0,    -2,   0,    0,    0};
    vecs[6]  = '{"minusOne",   0,     -1,     0,    -1,   0,    0,    0};
    vecs[7]  = '{"belowOne",   12,    1,      0,    0,    0,    0,    0};
    vecs[8]  = '{"exactOne",   13,    1,      0,    1,    0,    1,    0};
    vecs[9]  = '{"maxEdge",    2047,  0,      0,    127,  0,    127,  0};
    vecs[10] = '{"justUnder",  2031,  0,      0,    126,  0,    126,  0};
    vecs[11] = '{"overMax",    2048,  0,      0,    127,  0,    127,  0};
    vecs[12] = '{"minEdge",    -2048, 0,      0,    -128, 0,    0,    0};
    vecs[13] = '{"underMin",   -2049, 0,      0,    -128, 0,    0,    0};
    vecs[14] = '{"negRamp",    0,     0,      -16,  0,    -3,   0,    0};

    // Reset state
    #1;
    checkOutput("reset out_valid", int'(out_valid), 0);
    checkOutput("reset out_data", int'(out_data), 0);
    checkOutput("reset out_last", int'(out_last), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset done", int'(done), 0);
    checkOutput("reset drop_err", int'(drop_err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven rows
    for (int v = 0; v < 15; v++) begin
`ifdef RELU_EN
      eBase = vecs[v].rBase;
      eStep = vecs[v].rStep;
`else
      eBase = vecs[v].sBase;
      eStep = vecs[v].sStep;
`endif
      startRow(vecs[v].name, vecs[v].bias);
      applyStimulus(vecs[v].name, vecs[v].base, vecs[v].scale, 1'b0, -1);
      collectRow(vecs[v].name, eBase, eStep, 1'b0, ROW_LEN, 1'b0);
    end

    // Random input stalls and 1-in-3 backpressure on a ramp row
    startRow("stall", 0);
    applyStimulus("stall", 16, 16, 1'b1, -1);
    collectRow("stall", 3, 3, 1'b1, ROW_LEN, 1'b0);

    // Start in the done cycle is ignored, then a normal row still works
    startRow("startOnDone", 0);
    applyStimulus("startOnDone", 16, 0, 1'b0, -1);
    collectRow("startOnDone", 3, 0, 1'b0, ROW_LEN, 1'b1);
    startRow("afterDone", 40);
    applyStimulus("afterDone", -8, 0, 1'b0, -1);
    collectRow("afterDone", 1, 0, 1'b0, ROW_LEN, 1'b0);
    checkOutput("clean rows drop_err", int'(drop_err), 0);

    // Sample while idle is dropped and flagged, nothing is emitted
    @(negedge clk);
    psum_valid = 1'b1;
    psum_in    = 18'(500);
    @(negedge clk);
    psum_valid = 1'b0;
    checkOutput("idle drop drop_err", int'(drop_err), 1);
    checkOutput("idle drop out_valid", int'(out_valid), 0);
    checkOutput("idle drop busy", int'(busy), 0);

    // Stray start mid-accumulation (with a different bias) is ignored
    startRow("midStart", 0);
    applyStimulus("midStart", 16, 0, 1'b0, 30);
    collectRow("midStart", 3, 0, 1'b0, ROW_LEN, 1'b0);
    checkOutput("drop_err sticky", int'(drop_err), 1);

    // Reset during drain at k=10 aborts the row
    startRow("abort", 0);
    applyStimulus("abort", 16, 16, 1'b0, -1);
    collectRow("abort", 3, 3, 1'b0, 10, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("abort out_valid", int'(out_valid), 0);
    checkOutput("abort out_data", int'(out_data), 0);
    checkOutput("abort out_last", int'(out_last), 0);
    checkOutput("abort busy", int'(busy), 0);
    checkOutput("abort done", int'(done), 0);
    checkOutput("abort drop_err cleared", int'(drop_err), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    startRow("fresh", 40);
    applyStimulus("fresh", -8, 0, 1'b0, -1);
    collectRow("fresh", 1, 0, 1'b0, ROW_LEN, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
